// File: rtl/gelato_ifetch_idecode_queue_if.sv
// Fetch-to-decode queue bus: the fetch-side push handshake, the decode-side
// pop handshake, the squash controls and the occupancy count. The queue
// itself uses the slave modport; whoever drives the fetch side, consumes the
// decode side and issues flushes uses the master modport.
interface gelato_ifetch_idecode_queue_if #(
  parameter int DEPTH                 = 4,
  parameter int ADDR_WIDTH            = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int WARP_NUM_WIDTH        = 5,
  parameter int SPLIT_TABLE_NUM_WIDTH = 4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch side
  logic                             in_valid;
  logic                             in_ready;
  logic [ADDR_WIDTH-1:0]            in_pc;
  logic [WARP_NUM_WIDTH-1:0]        in_warp_num;
  logic [SPLIT_TABLE_NUM_WIDTH-1:0] in_split_table_num;
  logic [DATA_WIDTH-1:0]            in_inst;

  // decode side
  logic                             out_valid;
  logic                             out_ready;
  logic [ADDR_WIDTH-1:0]            out_pc;
  logic [WARP_NUM_WIDTH-1:0]        out_warp_num;
  logic [SPLIT_TABLE_NUM_WIDTH-1:0] out_split_table_num;
  logic [DATA_WIDTH-1:0]            out_inst;

  // squash controls
  logic                             flush_valid;
  logic [WARP_NUM_WIDTH-1:0]        flush_warp_num;
  logic                             flush_all;

  // occupancy, squashed-but-undrained slots included
  logic [CNT_W-1:0]                 count;

  modport slave (
    input  in_valid, in_pc, in_warp_num, in_split_table_num, in_inst,
    output in_ready,
    output out_valid, out_pc, out_warp_num, out_split_table_num, out_inst,
    input  out_ready,
    input  flush_valid, flush_warp_num, flush_all,
    output count
  );

  modport master (
    output in_valid, in_pc, in_warp_num, in_split_table_num, in_inst,
    input  in_ready,
    input  out_valid, out_pc, out_warp_num, out_split_table_num, out_inst,
    output out_ready,
    output flush_valid, flush_warp_num, flush_all,
    input  count
  );

endinterface

// File: rtl/gelato_ifetch_idecode_queue.sv
// Circular buffer between I-Fetch and I-Decode. Each slot carries
// {pc, warp_num, split_table_num, inst} plus a live bit. Flushes clear live
// bits in place; a squashed slot reaching the head is dropped on its own
// without ever being shown to the decoder. Push-to-output latency is one
// cycle (no bypass), and at most one slot leaves per cycle.
module gelato_ifetch_idecode_queue #(
  parameter int DEPTH                 = 4,
  parameter int ADDR_WIDTH            = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int WARP_NUM_WIDTH        = 5,
  parameter int SPLIT_TABLE_NUM_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  gelato_ifetch_idecode_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // What the slot at the read pointer currently represents.
  typedef enum logic [1:0] {
    HEAD_EMPTY,
    HEAD_LIVE,
    HEAD_DEAD
  } head_state_e;

  // slot storage
  logic [ADDR_WIDTH-1:0]            pc_q    [DEPTH];
  logic [ADDR_WIDTH-1:0]            pc_d    [DEPTH];
  logic [WARP_NUM_WIDTH-1:0]        warp_q  [DEPTH];
  logic [WARP_NUM_WIDTH-1:0]        warp_d  [DEPTH];
  logic [SPLIT_TABLE_NUM_WIDTH-1:0] split_q [DEPTH];
  logic [SPLIT_TABLE_NUM_WIDTH-1:0] split_d [DEPTH];
  logic [DATA_WIDTH-1:0]            inst_q  [DEPTH];
  logic [DATA_WIDTH-1:0]            inst_d  [DEPTH];
  logic [DEPTH-1:0]                 live_q;
  logic [DEPTH-1:0]                 live_d;

  // pointers and occupancy
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // handshake / control terms
  head_state_e head_state;
  logic        in_ready;
  logic        out_valid;
  logic        push;
  logic        pop;
  logic        dead_drop;
  logic        remove;
  logic        push_squashed;

  // Classify the head slot: nothing there, something to present, or a
  // squashed leftover that has to be drained.
  always_comb begin
    head_state = HEAD_EMPTY;
    if (count_q != '0) begin
      if (live_q[rd_ptr_q]) begin
        head_state = HEAD_LIVE;
      end else begin
        head_state = HEAD_DEAD;
      end
    end
  end

  // Handshake decode. out_valid is gated by rst_n so no pop can complete in
  // a reset cycle; a push that coincides with a matching flush still
  // completes but lands already squashed.
  always_comb begin
    in_ready      = (count_q != FULL_CNT);
    out_valid     = rst_n && (head_state == HEAD_LIVE);
    push          = bus.in_valid && in_ready;
    pop           = out_valid && bus.out_ready;
    dead_drop     = rst_n && (head_state == HEAD_DEAD);
    remove        = pop || dead_drop;
    push_squashed = bus.flush_all ||
                    (bus.flush_valid && (bus.in_warp_num == bus.flush_warp_num));
  end

  assign bus.in_ready            = in_ready;
  assign bus.out_valid           = out_valid;
  assign bus.out_pc              = pc_q[rd_ptr_q];
  assign bus.out_warp_num        = warp_q[rd_ptr_q];
  assign bus.out_split_table_num = split_q[rd_ptr_q];
  assign bus.out_inst            = inst_q[rd_ptr_q];
  assign bus.count               = count_q;

  // Next-state for storage, pointers and count. The leaving head is retired
  // first, then flushes squash whatever remains, then the incoming entry is
  // written with its own squash decision. The write slot is never occupied
  // when a push happens, so these never collide on a live entry.
  always_comb begin
    pc_d     = pc_q;
    warp_d   = warp_q;
    split_d  = split_q;
    inst_d   = inst_q;
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (remove) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush_all ||
          (bus.flush_valid && (warp_q[i] == bus.flush_warp_num))) begin
        live_d[i] = 1'b0;
      end
    end

    if (push) begin
      pc_d[wr_ptr_q]    = bus.in_pc;
      warp_d[wr_ptr_q]  = bus.in_warp_num;
      split_d[wr_ptr_q] = bus.in_split_table_num;
      inst_d[wr_ptr_q]  = bus.in_inst;
      live_d[wr_ptr_q]  = !push_squashed;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({push, remove})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset; payloads are cleared
  // too so the output fields read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        warp_q[i]  <= '0;
        split_q[i] <= '0;
        inst_q[i]  <= '0;
      end
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      warp_q   <= warp_d;
      split_q  <= split_d;
      inst_q   <= inst_d;
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_gelato_ifetch_idecode_queue.sv
// Self-checking bench for gelato_ifetch_idecode_queue: a queue-of-entries
// reference model checked every negedge, plus directed scenarios with
// hand-computed expectations on what the decoder actually receives.
module tb_gelato_ifetch_idecode_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [3:0]  stn;
    logic [31:0] inst;
    bit          live;
  } entry_t;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  entry_t      model[$];
  bit          modelReady;
  logic [31:0] gotPc[$];
  logic [4:0]  gotWarp[$];

  gelato_ifetch_idecode_queue_if #(.DEPTH(DEPTH)) bus ();

  gelato_ifetch_idecode_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; returns 2 time units after the sampling edge.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [4:0] w,
                               input bit ordy, input bit fv = 1'b0,
                               input logic [4:0] fw = 5'd0, input bit fa = 1'b0);
    bus.in_valid           = v;
    bus.in_pc              = pc;
    bus.in_warp_num        = w;
    bus.in_split_table_num = pc[7:4];
    bus.in_inst            = ~pc ^ {27'd0, w};
    bus.out_ready          = ordy;
    bus.flush_valid        = fv;
    bus.flush_warp_num     = fw;
    bus.flush_all          = fa;
    @(posedge clk);
    #2;
  endtask

  // Reference model: leave the head (drop if squashed, pop if accepted),
  // squash the survivors, then append the incoming entry.
  always @(posedge clk) begin
    entry_t e;
    bit     wasFull;
    bit     squash;
    if (!rst_n) begin
      model.delete();
      modelReady = 1'b1;
    end else if (modelReady) begin
      wasFull = (model.size() == DEPTH);
      if (model.size() > 0) begin
        if (!model[0].live || bus.out_ready) void'(model.pop_front());
      end
      for (int k = 0; k < model.size(); k++) begin
        if (bus.flush_all || (bus.flush_valid && model[k].warp == bus.flush_warp_num))
          model[k].live = 1'b0;
      end
      if (bus.in_valid && !wasFull) begin
        squash = bus.flush_all || (bus.flush_valid && bus.in_warp_num == bus.flush_warp_num);
        e.pc   = bus.in_pc;
        e.warp = bus.in_warp_num;
        e.stn  = bus.in_split_table_num;
        e.inst = bus.in_inst;
        e.live = !squash;
        model.push_back(e);
      end
    end
  end

  // Record what the decoder really accepts from the DUT.
  always @(posedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      gotPc.push_back(bus.out_pc);
      gotWarp.push_back(bus.out_warp_num);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit expValid;
    if (modelReady) begin
      expValid = rst_n && (model.size() > 0) && model[0].live;
      checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
      checkOutput("count", {29'd0, bus.count}, model.size());
      checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, model.size() != DEPTH});
      if (expValid) begin
        checkOutput("out_pc", bus.out_pc, model[0].pc);
        checkOutput("out_warp_num", {27'd0, bus.out_warp_num}, {27'd0, model[0].warp});
        checkOutput("out_split_table_num", {28'd0, bus.out_split_table_num}, {28'd0, model[0].stn});
        checkOutput("out_inst", bus.out_inst, model[0].inst);
      end
    end
  end

  initial begin
    int expC[4];
    bit expV[4];
    tests      = 0;
    fails      = 0;
    modelReady = 1'b0;
    rst_n      = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;

    // reset state
    checkOutput("rst_count", {29'd0, bus.count}, 0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 1);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 0);
    checkOutput("rst_out_pc", bus.out_pc, 0);

    // fill then drain
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h100 + 4 * i, 5'(i), 0);
    checkOutput("fill_count", {29'd0, bus.count}, 4);
    checkOutput("fill_in_ready", {31'd0, bus.in_ready}, 0);
    checkOutput("fill_head_valid", {31'd0, bus.out_valid}, 1);
    checkOutput("fill_head_pc", bus.out_pc, 32'h100);
    gotPc.delete(); gotWarp.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("drain_n", gotPc.size(), 4);
    for (int i = 0; i < 4 && i < gotPc.size(); i++) checkOutput("drain_pc", gotPc[i], 32'h100 + 4 * i);
    checkOutput("drain_count", {29'd0, bus.count}, 0);

    // steady push+pop at count 2 across pointer wrap
    gotPc.delete(); gotWarp.delete();
    applyStimulus(1, 32'h300, 0, 0);
    applyStimulus(1, 32'h304, 0, 0);
    checkOutput("steady_start_count", {29'd0, bus.count}, 2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 32'h308 + 4 * k, 5'(k % 3), 1);
      checkOutput("steady_count", {29'd0, bus.count}, 2);
    end
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("steady_n", gotPc.size(), 12);
    for (int i = 0; i < 12 && i < gotPc.size(); i++) checkOutput("steady_pc", gotPc[i], 32'h300 + 4 * i);

    // per-warp flush of warp 3 out of {3,5,3,7}
    gotPc.delete(); gotWarp.delete();
    applyStimulus(1, 32'h400, 3, 0);
    applyStimulus(1, 32'h404, 5, 0);
    applyStimulus(1, 32'h408, 3, 0);
    applyStimulus(1, 32'h40C, 7, 0);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("wflush_count", {29'd0, bus.count}, 4);
    expC = '{3, 2, 1, 0};
    expV = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      checkOutput("wflush_valid", {31'd0, bus.out_valid}, {31'd0, expV[i]});
      applyStimulus(0, 0, 0, 1);
      checkOutput("wflush_cnt", {29'd0, bus.count}, expC[i]);
    end
    checkOutput("wflush_n", gotPc.size(), 2);
    if (gotPc.size() == 2) begin
      checkOutput("wflush_pc0", gotPc[0], 32'h404);
      checkOutput("wflush_warp0", {27'd0, gotWarp[0]}, 5);
      checkOutput("wflush_pc1", gotPc[1], 32'h40C);
      checkOutput("wflush_warp1", {27'd0, gotWarp[1]}, 7);
    end

    // push coinciding with flush of the same / a different warp
    gotPc.delete(); gotWarp.delete();
    checkOutput("fpush_in_ready", {31'd0, bus.in_ready}, 1);
    applyStimulus(1, 32'h200, 2, 0, 1, 2);
    checkOutput("fpush_count", {29'd0, bus.count}, 1);
    checkOutput("fpush_dead_valid", {31'd0, bus.out_valid}, 0);
    applyStimulus(1, 32'h204, 4, 1, 1, 2);
    checkOutput("fpush_live_valid", {31'd0, bus.out_valid}, 1);
    checkOutput("fpush_live_pc", bus.out_pc, 32'h204);
    applyStimulus(0, 0, 0, 1);
    checkOutput("fpush_n", gotPc.size(), 1);
    if (gotPc.size() == 1) checkOutput("fpush_pc", gotPc[0], 32'h204);

    // flush_all on a full queue with fetch still pushing
    gotPc.delete(); gotWarp.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h500 + 4 * i, 5'(i), 0);
    checkOutput("fall_in_ready", {31'd0, bus.in_ready}, 0);
    applyStimulus(1, 32'h510, 1, 0, 0, 0, 1);
    checkOutput("fall_count", {29'd0, bus.count}, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fall_valid", {31'd0, bus.out_valid}, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("fall_cnt", {29'd0, bus.count}, 3 - i);
    end
    checkOutput("fall_in_ready_end", {31'd0, bus.in_ready}, 1);
    checkOutput("fall_n", gotPc.size(), 0);

    // reset in the middle of operation
    gotPc.delete(); gotWarp.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h600 + 4 * i, 5'(i), 0);
    checkOutput("mrst_pre_count", {29'd0, bus.count}, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_forced_valid", {31'd0, bus.out_valid}, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mrst_count", {29'd0, bus.count}, 0);
    checkOutput("mrst_out_valid", {31'd0, bus.out_valid}, 0);
    checkOutput("mrst_in_ready", {31'd0, bus.in_ready}, 1);
    checkOutput("mrst_no_pop", gotPc.size(), 0);
    rst_n = 1'b1;
    applyStimulus(1, 32'h700, 6, 0);
    checkOutput("mrst_push_valid", {31'd0, bus.out_valid}, 1);
    checkOutput("mrst_push_pc", bus.out_pc, 32'h700);
    checkOutput("mrst_push_warp", {27'd0, bus.out_warp_num}, 6);
    applyStimulus(0, 0, 0, 1);
    checkOutput("mrst_n", gotPc.size(), 1);
    if (gotPc.size() == 1) checkOutput("mrst_pc", gotPc[0], 32'h700);

    applyStimulus(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gelato_ifetch_idecode_queue.md
Name: gelato_ifetch_idecode_queue

Overview:
- Parametrised, depth-configurable buffer between I-Fetch and I-Decode carrying {pc, warp_num, split_table_num, inst}.
- Adds a ready/valid backpressure handshake and per-warp / global flush, which a plain fetch→decode wire bundle lacks.
- Flushed entries are squashed in place and drained without ever being presented to I-Decode.
- Sits between the fetch unit and the decoder; the decoder stalls fetch through in_ready.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- ADDR_WIDTH, 32, pc width.
- DATA_WIDTH, 32, instruction width.
- WARP_NUM_WIDTH, 5, warp_num width.
- SPLIT_TABLE_NUM_WIDTH, 4, split_table_num width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept.
- in_pc  in  ADDR_WIDTH  fetch pc.
- in_warp_num  in  WARP_NUM_WIDTH  owning warp.
- in_split_table_num  in  SPLIT_TABLE_NUM_WIDTH  split-table entry.
- in_inst  in  DATA_WIDTH  instruction word.
- out_valid  out  1  live entry at head.
- out_ready  in  1  decoder accepts.
- out_pc / out_warp_num / out_split_table_num / out_inst  out  as inputs  head entry fields.
- flush_valid  in  1  squash one warp.
- flush_warp_num  in  WARP_NUM_WIDTH  warp to squash.
- flush_all  in  1  squash every entry.
- count  out  $clog2(DEPTH+1)  occupied slots, including squashed entries.

Behaviour:
- Clocking: single clock; reset is synchronous, active-low, sampled at the clk rising edge.
- Reset: rd_ptr=0, wr_ptr=0, count=0, all live bits=0, out_valid=0, in_ready=1. out_* data fields are 0 after reset and hold the slot contents thereafter.
- Storage:
  - Circular array of DEPTH slots; each slot holds payload plus a live bit.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- in_ready = (count != DEPTH). There is no same-cycle pass-through when full.
- Push: in_valid && in_ready.
  - Writes slot[wr_ptr] with live=1 and advances wr_ptr.
  - Latency is 1 cycle: an entry pushed in cycle N is visible at out_* at earliest in N+1. There is no bypass when empty.
- Head states:
  - EMPTY (count==0): out_valid=0.
  - LIVE (count>0, slot[rd_ptr].live=1): out_valid=1; out_* = slot[rd_ptr].
  - DEAD (count>0, live=0): out_valid=0; the slot is discarded automatically that cycle (rd_ptr++, count--), independent of out_ready.
- Pop: out_valid && out_ready advances rd_ptr and decrements count. At most one slot is removed per cycle (pop or dead-drop).
- count next value = count + push − (pop | dead_drop). Simultaneous push and pop keeps count unchanged.
- Flush (effect visible the cycle after assertion):
  - flush_all clears the live bit of every slot.
  - flush_valid clears the live bit of every slot with warp_num == flush_warp_num.
  - Squashed slots still occupy count until drained.
  - A head popped in the same cycle as a matching flush counts as delivered; flush affects only the slots remaining after that edge.
  - A push in the same cycle as a matching flush (same warp, or flush_all) completes the handshake but is written with live=0.
  - flush_all and flush_valid may both be asserted; flush_all dominates.
- Ordering: live entries leave in push order; squashed entries are never presented.
- Reset mid-operation: all contents are discarded next edge and no out handshake completes in the reset cycle. out_valid is forced to 0 while rst_n=0.

Test Plan:
- Fill/drain: DEPTH=4, out_ready=0, push pc 0x100,0x104,0x108,0x10C → in_ready=0 after 4th, count=4. Then out_ready=1 → four pops in order, 0x100 on the first cycle.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2, order preserved, pointers wrap without loss.
- Per-warp flush: queue holds warps {3,5,3,7}, flush_valid warp 3 → out shows warp5 then warp7 only. count drops 4→0 in exactly 4 cycles with out_ready=1, including 2 dead-drop cycles with out_valid=0.
- Same-cycle flush+push: push warp 2 pc 0x200 while flush_valid warp 2 → in_ready=1, handshake completes, entry never appears at out. Push warp 4 with the same flush → entry delivered.
- flush_all with a full queue and in_valid=1 → in_ready=0 that cycle. count decreases by 1 per cycle to 0 with out_valid=0 throughout, then in_ready=1.
- Reset: assert rst_n=0 with count=3 → next edge count=0, out_valid=0, in_ready=1. The first push after release appears at out one cycle later.
